// File: rtl/outbox_tx_bridge.sv
// OUTBOX -> UART bridge: elastic word buffer, byte serialiser and word counter.
// Optional hex-ASCII formatting is compiled in when OUTBOX_TX_HEX_EN is defined.
module outbox_tx_bridge #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  SEP_CHAR = 8'h0A,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_src_empty,
  input  logic [DATA_W-1:0]          i_src_data,
  output logic                       o_src_pop,
  output logic                       o_tx_wr,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_busy,
  input  logic                       i_hex_mode,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [CNT_W-1:0]           o_word_cnt,
  output logic                       o_active
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned NBYTES  = DATA_W / 8;
  localparam int unsigned LEFT_W  = 4;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_pop;
  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_shift, w_shift_d;
  logic [LEFT_W-1:0] r_left, w_left_d;
  logic              r_tx_wr, w_tx_wr_d;
  logic [7:0]        r_tx_data, w_tx_data_d;
  logic [CNT_W-1:0]  r_word_cnt;
  logic              w_rd, w_load, w_next, w_cnt_inc;
  logic [DATA_W-1:0] w_head;

`ifdef OUTBOX_TX_HEX_EN
  localparam int unsigned NDIGITS = DATA_W / 4;
  logic r_hex, w_hex_d;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`else
  logic [8:0] w_unused_cfg;
  assign w_unused_cfg = {i_hex_mode, SEP_CHAR};
`endif

  assign w_head = r_buf[r_rptr];

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_left_d    = r_left;
    w_tx_wr_d   = 1'b0;
    w_tx_data_d = r_tx_data;
    w_rd        = 1'b0;
    w_load      = 1'b0;
    w_next      = 1'b0;
    w_cnt_inc   = 1'b0;
`ifdef OUTBOX_TX_HEX_EN
    w_hex_d     = r_hex;
`endif
    unique case (r_state)
      StIdle: if (r_level != '0) w_load = 1'b1;
      StSend: w_state_d = StWait;
      StWait: begin
        if (!i_tx_busy) begin
          if (r_left != '0) begin
            w_next = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
            if (r_level != '0) w_load = 1'b1;
            else               w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_load) begin
      w_rd        = 1'b1;
      w_state_d   = StSend;
      w_tx_wr_d   = 1'b1;
      w_tx_data_d = w_head[DATA_W-1 -: 8];
      w_shift_d   = w_head << 8;
      w_left_d    = LEFT_W'(NBYTES - 1);
`ifdef OUTBOX_TX_HEX_EN
      w_hex_d     = i_hex_mode;
      if (i_hex_mode) begin
        w_tx_data_d = f_hex(w_head[DATA_W-1 -: 4]);
        w_shift_d   = w_head << 4;
        // Remaining digits plus the trailing separator.
        w_left_d    = LEFT_W'(NDIGITS);
      end
`endif
    end

    if (w_next) begin
      w_state_d   = StSend;
      w_tx_wr_d   = 1'b1;
      w_left_d    = r_left - 1'b1;
      w_tx_data_d = r_shift[DATA_W-1 -: 8];
      w_shift_d   = r_shift << 8;
`ifdef OUTBOX_TX_HEX_EN
      if (r_hex) begin
        if (r_left == LEFT_W'(1)) begin
          w_tx_data_d = SEP_CHAR;
          w_shift_d   = r_shift;
        end else begin
          w_tx_data_d = f_hex(r_shift[DATA_W-1 -: 4]);
          w_shift_d   = r_shift << 4;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pop      <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_state    <= StIdle;
      r_shift    <= '0;
      r_left     <= '0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= '0;
      r_word_cnt <= '0;
    end else begin
      // Never pop on consecutive cycles: covers the OUTBOX empty-flag lag.
      r_pop <= ~i_src_empty & ~r_pop & (r_level < FULL_LVL);
      if (r_pop) r_wptr <= r_wptr + 1'b1;
      if (w_rd)  r_rptr <= r_rptr + 1'b1;
      if (r_pop && !w_rd)      r_level <= r_level + 1'b1;
      else if (!r_pop && w_rd) r_level <= r_level - 1'b1;
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_left    <= w_left_d;
      r_tx_wr   <= w_tx_wr_d;
      r_tx_data <= w_tx_data_d;
      if (w_cnt_inc) r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

`ifdef OUTBOX_TX_HEX_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_hex <= 1'b0;
    else          r_hex <= w_hex_d;
  end
`endif

  // Storage needs no reset: o_level gates every read.
  always_ff @(posedge clk) begin
    if (r_pop) r_buf[r_wptr] <= i_src_data;
  end

  assign o_src_pop  = r_pop;
  assign o_tx_wr    = r_tx_wr;
  assign o_tx_data  = r_tx_data;
  assign o_level    = r_level;
  assign o_word_cnt = r_word_cnt;
  assign o_active   = (r_level != '0) || (r_state != StIdle);

endmodule

// File: tb/tb_outbox_tx_bridge.sv
// Directed bench: DUT A (8-bit words, CNT_W=16) and DUT B (16-bit words, CNT_W=2)
// fed by OUTBOX and UART models; expectations are hand-computed.
module tb_outbox_tx_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // DUT A
  logic        a_empty = 1'b1;
  logic [7:0]  a_data = '0;
  logic        a_pop, a_wr, a_busy, a_active;
  logic        a_hex = 1'b0;
  logic        a_hold = 1'b0;
  logic [7:0]  a_txd;
  logic [2:0]  a_level;
  logic [15:0] a_cnt;
  logic [7:0]  a_q[$];
  logic [7:0]  a_log[$];
  int          a_bcnt = 0;
  int          a_npop = 0;
  int          a_maxlvl = 0;

  // DUT B
  logic        b_empty = 1'b1;
  logic [15:0] b_data = '0;
  logic        b_pop, b_wr, b_busy, b_active;
  logic [7:0]  b_txd;
  logic [2:0]  b_level;
  logic [1:0]  b_cnt;
  logic [15:0] b_q[$];
  logic [7:0]  b_log[$];
  int          b_tlog[$];
  int          b_bcnt = 0;

  outbox_tx_bridge #(.DATA_W(8), .DEPTH(4), .SEP_CHAR(8'h0A), .CNT_W(16)) u_dut_a (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_src_empty(a_empty),
    .i_src_data (a_data),
    .o_src_pop  (a_pop),
    .o_tx_wr    (a_wr),
    .o_tx_data  (a_txd),
    .i_tx_busy  (a_busy),
    .i_hex_mode (a_hex),
    .o_level    (a_level),
    .o_word_cnt (a_cnt),
    .o_active   (a_active)
  );

  outbox_tx_bridge #(.DATA_W(16), .DEPTH(4), .SEP_CHAR(8'h0A), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_src_empty(b_empty),
    .i_src_data (b_data),
    .o_src_pop  (b_pop),
    .o_tx_wr    (b_wr),
    .o_tx_data  (b_txd),
    .i_tx_busy  (b_busy),
    .i_hex_mode (1'b0),
    .o_level    (b_level),
    .o_word_cnt (b_cnt),
    .o_active   (b_active)
  );

  // OUTBOX models: the head word leaves on the edge that ends the pop cycle
  always @(posedge clk) if (a_pop) begin #1; if (a_q.size() > 0) void'(a_q.pop_front()); end
  always @(posedge clk) if (b_pop) begin #1; if (b_q.size() > 0) void'(b_q.pop_front()); end
  always @(negedge clk) begin
    a_empty = (a_q.size() == 0);
    a_data  = a_empty ? 8'h00 : a_q[0];
    b_empty = (b_q.size() == 0);
    b_data  = b_empty ? 16'h0000 : b_q[0];
  end

  // UART models: busy rises the cycle after the strobe (A: 10 cycles, B: 1 cycle)
  always @(posedge clk) begin
    if (a_wr) begin a_bcnt <= 10; a_log.push_back(a_txd); end
    else if (a_bcnt > 0) a_bcnt <= a_bcnt - 1;
    if (b_wr) begin b_bcnt <= 1; b_log.push_back(b_txd); b_tlog.push_back(cyc); end
    else if (b_bcnt > 0) b_bcnt <= b_bcnt - 1;
    if (a_pop) a_npop <= a_npop + 1;
    if (int'(a_level) > a_maxlvl) a_maxlvl <= int'(a_level);
  end
  assign a_busy = (a_bcnt != 0) || a_hold;
  assign b_busy = (b_bcnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sel == 1'b0 ? (!a_active && a_q.size() == 0 && a_bcnt == 0 && !a_pop)
                      : (!b_active && b_q.size() == 0 && b_bcnt == 0 && !b_pop)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_pop", {31'd0, a_pop}, 32'd0);
    chk("rst_wr", {31'd0, a_wr}, 32'd0);
    chk("rst_txd", {24'd0, a_txd}, 32'd0);
    chk("rst_level", {29'd0, a_level}, 32'd0);
    chk("rst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("rst_active", {31'd0, a_active}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single raw byte
    a_q.push_back(8'h41);
    wait_idle(1'b0, "single_idle");
    chk("single_nbytes", a_log.size(), 32'd1);
    chk("single_byte", {24'd0, a_log[0]}, 32'h41);
    chk("single_cnt", {16'd0, a_cnt}, 32'd1);
    chk("single_npop", a_npop, 32'd1);

    // Buffer saturation with the UART held busy
    a_log.delete();
    a_hold = 1'b1;
    for (int i = 1; i <= 6; i++) a_q.push_back(8'(i));
    repeat (40) @(negedge clk);
    chk("full_level", {29'd0, a_level}, 32'd4);
    chk("full_pop", {31'd0, a_pop}, 32'd0);
    chk("full_src_left", a_q.size(), 32'd1);
    chk("full_sent", a_log.size(), 32'd1);
    repeat (5) @(negedge clk);
    chk("full_pop_later", {31'd0, a_pop}, 32'd0);
    a_hold = 1'b0;
    wait_idle(1'b0, "full_idle");
    chk("full_nbytes", a_log.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk("full_order", {24'd0, a_log[i]}, 32'(i + 1));
    chk("full_cnt", {16'd0, a_cnt}, 32'd7);
    chk("full_maxlvl", a_maxlvl, 32'd4);

    // Hex formatting (or its absence in the default build)
    a_log.delete();
    a_hex = 1'b1;
    a_q.push_back(8'h3C);
`ifdef OUTBOX_TX_HEX_EN
    for (int i = 0; i < 200 && a_log.size() == 0; i++) @(negedge clk);
    a_hex = 1'b0;
    wait_idle(1'b0, "hex_idle");
    chk("hex_nbytes", a_log.size(), 32'd3);
    chk("hex_b0", {24'd0, a_log[0]}, 32'h33);
    chk("hex_b1", {24'd0, a_log[1]}, 32'h43);
    chk("hex_b2", {24'd0, a_log[2]}, 32'h0A);
`else
    wait_idle(1'b0, "hex_idle");
    a_hex = 1'b0;
    chk("hexoff_nbytes", a_log.size(), 32'd1);
    chk("hexoff_b0", {24'd0, a_log[0]}, 32'h3C);
`endif
    chk("hex_cnt", {16'd0, a_cnt}, 32'd8);

    // 16-bit raw words on DUT B, counter wraps at 4
    b_q.push_back(16'hBEEF);
    wait_idle(1'b1, "w16_idle");
    chk("w16_nbytes", b_log.size(), 32'd2);
    chk("w16_b0", {24'd0, b_log[0]}, 32'hBE);
    chk("w16_b1", {24'd0, b_log[1]}, 32'hEF);
    chk("w16_spacing", {31'd0, (b_tlog[1] - b_tlog[0]) >= 3}, 32'd1);
    chk("w16_cnt", {30'd0, b_cnt}, 32'd1);
    for (int i = 1; i <= 4; i++) b_q.push_back(16'(i));
    wait_idle(1'b1, "wrap_idle");
    chk("wrap_nbytes", b_log.size(), 32'd10);
    chk("wrap_b2", {24'd0, b_log[2]}, 32'h00);
    chk("wrap_b3", {24'd0, b_log[3]}, 32'h01);
    chk("wrap_b9", {24'd0, b_log[9]}, 32'h04);
    chk("wrap_cnt", {30'd0, b_cnt}, 32'd1);

    // Asynchronous reset mid-word with three words buffered
    a_log.delete();
    a_hold = 1'b1;
    for (int i = 1; i <= 4; i++) a_q.push_back(8'hA0 + 8'(i));
    repeat (30) @(negedge clk);
    chk("prerst_level", {29'd0, a_level}, 32'd3);
    chk("prerst_txd", {24'd0, a_txd}, 32'hA1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pop", {31'd0, a_pop}, 32'd0);
    chk("midrst_wr", {31'd0, a_wr}, 32'd0);
    chk("midrst_txd", {24'd0, a_txd}, 32'd0);
    chk("midrst_level", {29'd0, a_level}, 32'd0);
    chk("midrst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("midrst_active", {31'd0, a_active}, 32'd0);
    n = a_log.size();
    @(negedge clk);
    rst_n = 1'b1;
    a_hold = 1'b0;
    repeat (40) @(negedge clk);
    chk("postrst_nbytes", a_log.size(), 32'(n));
    chk("postrst_level", {29'd0, a_level}, 32'd0);
    chk("postrst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("postrst_active", {31'd0, a_active}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/outbox_tx_bridge.md
# outbox_tx_bridge

Parametrised bridge between the CPU OUTBOX (first-word-fall-through, empty flag plus pop strobe) and the UART transmitter (write strobe plus busy flag). It is the successor to the single-byte pop controller. It adds:
- a DEPTH-entry elastic buffer, so the OUTBOX drains while the UART is busy;
- DATA_W words serialised as multiple bytes;
- an optional hex-ASCII formatting mode;
- status counters.

It sits at top level between `hrmcpu` and `txuartlite`.

## Interface
Parameters:
- DATA_W, 8: OUTBOX word width; multiple of 8, range 8..32.
- DEPTH, 4: buffer entries; power of two, at least 2.
- SEP_CHAR, 8'h0A: byte appended after each word in hex mode.
- CNT_W, 16: width of the word counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_src_empty  in  1  OUTBOX empty.
- i_src_data  in  DATA_W  OUTBOX head word; valid while not empty.
- o_src_pop  out  1  registered pop strobe; the word is captured at the edge that ends the pop-high cycle.
- o_tx_wr  out  1  registered one-cycle UART write strobe.
- o_tx_data  out  8  byte to transmit; valid while o_tx_wr is high.
- i_tx_busy  in  1  UART busy; rises the cycle after o_tx_wr.
- i_hex_mode  in  1  formatting select, sampled per word; ignored unless the macro is defined.
- o_level  out  $clog2(DEPTH)+1  buffer occupancy.
- o_word_cnt  out  CNT_W  words fully transmitted; wraps modulo 2^CNT_W.
- o_active  out  1  high while o_level != 0 or the serialiser is not in IDLE.

## Operation
Source side:
- At each edge, o_src_pop <= ~i_src_empty & ~o_src_pop & (o_level < DEPTH).
- o_src_pop is therefore never high on two consecutive cycles. This covers the empty-flag update lag of the OUTBOX.
- On the edge that ends a pop-high cycle, i_src_data is written at the buffer write pointer.
- Pointers wrap modulo DEPTH.
- A simultaneous buffer write and read leaves o_level unchanged.

Serialiser FSM, with states IDLE, SEND and WAIT:
- IDLE: if o_level != 0, read the head word into the shift register, latch the mode, load the character counter, drive the first byte with o_tx_wr=1, and go to SEND.
- SEND: o_tx_wr=0; go to WAIT unconditionally. This is the one-cycle holdoff for busy to rise.
- WAIT, while i_tx_busy=1: stay in WAIT.
- WAIT, when i_tx_busy=0:
  - If characters remain, issue the next byte and go to SEND.
  - Otherwise increment o_word_cnt. If o_level != 0, load the next word and issue its first byte (SEND). If o_level = 0, go to IDLE.

Formatting:
- Raw mode emits DATA_W/8 bytes, MSB byte first.
- Hex mode emits DATA_W/4 uppercase ASCII digits, MSB nibble first ('0'-'9' = 8'h30-8'h39, 'A'-'F' = 8'h41-8'h46), then SEP_CHAR.
- The mode is latched at word load. Toggling i_hex_mode mid-word does not affect that word.

Boundaries:
- Buffer full: no pop is issued. Popping resumes on the edge after the serialiser frees an entry.
- Buffer empty with the FSM in WAIT: o_word_cnt still increments when busy falls.
- Reset asserted mid-operation: all state clears immediately. Buffered words and the partially sent word are discarded and not counted. A byte already accepted by the UART completes outside this block.

## Timing
- Reset values: o_src_pop=0, o_tx_wr=0, o_tx_data=0, o_level=0, o_word_cnt=0, o_active=0. The FSM resets to IDLE and both pointers to 0.
- OUTBOX non-empty to o_src_pop high: 1 cycle.
- Buffer write to o_tx_wr high, with the FSM in IDLE: 1 cycle (level visible, then strobe registered).
- Minimum spacing between o_tx_wr strobes: 3 cycles (SEND, WAIT with busy seen low).
- Maximum source throughput: one word per 2 cycles.
- o_word_cnt updates on the edge that leaves WAIT after the last character.

## Configuration
- OUTBOX_TX_HEX_EN defined: hex formatting logic is compiled in and i_hex_mode is honoured.
- Undefined: i_hex_mode is ignored, every word uses raw mode, and SEP_CHAR is unused.

## Test plan
- Default parameters, raw mode: OUTBOX holds 8'h41, UART busy for 10 cycles per byte -> exactly one o_tx_wr with o_tx_data=8'h41; o_word_cnt=1; o_src_pop pulsed once.
- DEPTH=4: push 6 words 8'h01..8'h06 with the UART held busy -> o_level saturates at 4 and o_src_pop stays low. After release, bytes 01..06 are transmitted in order and o_word_cnt=6.
- DATA_W=16, raw mode: word 16'hBEEF -> bytes 8'hBE then 8'hEF, with o_tx_wr strobes at least 3 cycles apart.
- With OUTBOX_TX_HEX_EN, i_hex_mode=1: word 8'h3C -> bytes 8'h33, 8'h43, 8'h0A. Toggling i_hex_mode after the first byte changes nothing for this word.
- Assert i_rst_n=0 mid-word with 3 words buffered -> all outputs read 0 within the same cycle; after release, no stale bytes are emitted.
- CNT_W=2: send 5 words -> o_word_cnt reads 1 (wrap).
